// File: rtl/polybius_pair_assembler.sv
// Polybius pair assembler: turns an ASCII ciphertext byte stream into {row,col}
// digit pairs for the decrypt stage, dropping separators and flagging bad bytes.
module polybius_pair_assembler #(
  parameter int unsigned GRID = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] pair_out,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic        err_pulse,
  output logic [15:0] pair_count,
  output logic [7:0]  err_count
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PAIR_W  = 16;
  localparam int unsigned ERRC_W  = 8;
  localparam logic [BYTE_W-1:0] DIGIT_MIN = 8'h31;
  localparam logic [BYTE_W-1:0] DIGIT_MAX = BYTE_W'(32'h30 + GRID);
  localparam logic [PAIR_W-1:0] PAIR_SAT  = 16'hFFFF;
  localparam logic [ERRC_W-1:0] ERR_SAT   = 8'hFF;

  typedef enum logic [1:0] {
    ST_ROW  = 2'd0,
    ST_COL  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   row_q, row_d;
  logic [PAIR_W-1:0]   pair_out_d;
  logic                pair_valid_d;
  logic                in_ready_d;
  logic                err_d;
  logic [PAIR_W-1:0]   pair_count_d;
  logic [ERRC_W-1:0]   err_count_d;

  logic                accept_c;
  logic                is_digit_c;
  logic                is_sep_c;

  // Byte classification and handshake qualification.
  always_comb begin
    accept_c   = in_valid & in_ready;
    is_digit_c = (in_byte >= DIGIT_MIN) && (in_byte <= DIGIT_MAX);
    is_sep_c   = (in_byte == 8'h20) || (in_byte == 8'h0D) || (in_byte == 8'h0A);
  end

  // Next-state and next-output logic; clear overrides every data event.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    pair_out_d   = pair_out;
    pair_valid_d = pair_valid;
    err_d        = 1'b0;
    pair_count_d = pair_count;
    err_count_d  = err_count;

    if (clear) begin
      state_d      = ST_ROW;
      pair_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ROW: begin
          if (accept_c) begin
            if (is_digit_c) begin
              row_d   = in_byte;
              state_d = ST_COL;
            end else if (!is_sep_c) begin
              err_d = 1'b1;
            end
          end
        end
        ST_COL: begin
          if (accept_c) begin
            if (is_digit_c) begin
              pair_out_d   = {row_q, in_byte};
              pair_valid_d = 1'b1;
              state_d      = ST_FULL;
            end else begin
              // A separator or bad byte breaks the pair; the row digit is lost.
              err_d   = 1'b1;
              row_d   = '0;
              state_d = ST_ROW;
            end
          end
        end
        ST_FULL: begin
          if (pair_ready) begin
            pair_valid_d = 1'b0;
            state_d      = ST_ROW;
            if (pair_count != PAIR_SAT) begin
              pair_count_d = pair_count + PAIR_W'(1);
            end
          end
        end
        default: begin
          state_d      = ST_ROW;
          pair_valid_d = 1'b0;
        end
      endcase

      if (err_d && (err_count != ERR_SAT)) begin
        err_count_d = err_count + ERRC_W'(1);
      end
    end

    // Registered ready tracks the complement of the next pair_valid.
    in_ready_d = ~pair_valid_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ROW;
      row_q      <= '0;
      pair_out   <= '0;
      pair_valid <= 1'b0;
      in_ready   <= 1'b0;
      err_pulse  <= 1'b0;
      pair_count <= '0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      pair_out   <= pair_out_d;
      pair_valid <= pair_valid_d;
      in_ready   <= in_ready_d;
      err_pulse  <= err_d;
      pair_count <= pair_count_d;
      err_count  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_polybius_pair_assembler.sv
// Directed bench for polybius_pair_assembler with GRID = 7.
module tb_polybius_pair_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] pair_out;
  logic        pair_valid;
  logic        pair_ready;
  logic        err_pulse;
  logic [15:0] pair_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  polybius_pair_assembler #(.GRID(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pair_out   (pair_out),
    .pair_valid (pair_valid),
    .pair_ready (pair_ready),
    .err_pulse  (err_pulse),
    .pair_count (pair_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [7:0]  b;
    logic        pr;
    logic        ir;
    logic        pv;
    logic [15:0] po;
    logic        ep;
    logic [15:0] pc;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic clr, input logic iv, input logic [7:0] b,
                              input logic pr, input logic ir, input logic pv,
                              input logic [15:0] po, input logic ep,
                              input logic [15:0] pc, input logic [7:0] ec);
    vec_t v;
    v.clr = clr; v.iv = iv; v.b = b; v.pr = pr;
    v.ir = ir; v.pv = pv; v.po = po; v.ep = ep; v.pc = pc; v.ec = ec;
    return v;
  endfunction

  task automatic cmp(input string name, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", name, fld, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ir, input logic pv,
                           input logic [15:0] po, input logic ep,
                           input logic [15:0] pc, input logic [7:0] ec);
    cmp(name, "in_ready",   16'(in_ready),   16'(ir));
    cmp(name, "pair_valid", 16'(pair_valid), 16'(pv));
    cmp(name, "pair_out",   pair_out,        po);
    cmp(name, "err_pulse",  16'(err_pulse),  16'(ep));
    cmp(name, "pair_count", pair_count,      pc);
    cmp(name, "err_count",  16'(err_count),  16'(ec));
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic step(input logic c, input logic iv, input logic [7:0] b, input logic pr);
    @(negedge clk);
    clear = c; in_valid = iv; in_byte = b; pair_ready = pr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_byte = 8'h00; pair_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // clr iv byte pr | ir pv pair_out ep pc ec
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 16'h0000, 0, 16'd0, 8'd0)); // idle
    tbl.push_back(mk(0, 1, "3",   1, 1, 0, 16'h0000, 0, 16'd0, 8'd0));
    tbl.push_back(mk(0, 1, "4",   1, 0, 1, 16'h3334, 0, 16'd0, 8'd0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h3334, 0, 16'd1, 8'd0)); // handshake
    tbl.push_back(mk(0, 1, " ",   1, 1, 0, 16'h3334, 0, 16'd1, 8'd0));
    tbl.push_back(mk(0, 1, "1",   1, 1, 0, 16'h3334, 0, 16'd1, 8'd0));
    tbl.push_back(mk(0, 1, 8'h0A, 1, 1, 0, 16'h3334, 1, 16'd1, 8'd1)); // broken pair
    tbl.push_back(mk(0, 1, "7",   1, 1, 0, 16'h3334, 0, 16'd1, 8'd1));
    tbl.push_back(mk(0, 1, "7",   1, 0, 1, 16'h3737, 0, 16'd1, 8'd1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h3737, 0, 16'd2, 8'd1));
    tbl.push_back(mk(0, 1, "8",   1, 1, 0, 16'h3737, 1, 16'd2, 8'd2)); // above GRID
    tbl.push_back(mk(0, 1, "0",   1, 1, 0, 16'h3737, 1, 16'd2, 8'd3)); // below 1
    tbl.push_back(mk(0, 1, "A",   1, 1, 0, 16'h3737, 1, 16'd2, 8'd4));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h3737, 0, 16'd2, 8'd4));
    tbl.push_back(mk(0, 1, "2",   1, 1, 0, 16'h3737, 0, 16'd2, 8'd4));
    tbl.push_back(mk(0, 1, "x",   1, 1, 0, 16'h3737, 1, 16'd2, 8'd5)); // bad col
    tbl.push_back(mk(0, 1, "6",   0, 1, 0, 16'h3737, 0, 16'd2, 8'd5));
    tbl.push_back(mk(0, 1, "7",   0, 0, 1, 16'h3637, 0, 16'd2, 8'd5));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 16'h3637, 0, 16'd3, 8'd5));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].iv, tbl[i].b, tbl[i].pr);
      check_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].pv, tbl[i].po,
                tbl[i].ep, tbl[i].pc, tbl[i].ec);
    end

    // Backpressure: pair held, offered byte not consumed, count on release only.
    step(0, 1, "2", 0);
    check_all("bp_row", 1'b1, 1'b0, 16'h3637, 1'b0, 16'd3, 8'd5);
    step(0, 1, "5", 0);
    check_all("bp_col", 1'b0, 1'b1, 16'h3235, 1'b0, 16'd3, 8'd5);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, "1", 0);
      check_all($sformatf("bp_hold%0d", k), 1'b0, 1'b1, 16'h3235, 1'b0, 16'd3, 8'd5);
    end
    step(0, 0, 8'h00, 1);
    check_all("bp_release", 1'b1, 1'b0, 16'h3235, 1'b0, 16'd4, 8'd5);

    // Clear in COL drops the row and the offered byte; clear in FULL drops the pair.
    step(0, 1, "4", 0);
    check_all("clr_row", 1'b1, 1'b0, 16'h3235, 1'b0, 16'd4, 8'd5);
    step(1, 1, "5", 0);
    check_all("clr_col", 1'b1, 1'b0, 16'h3235, 1'b0, 16'd4, 8'd5);
    step(0, 1, "3", 0);
    step(0, 1, "2", 0);
    check_all("clr_pair", 1'b0, 1'b1, 16'h3332, 1'b0, 16'd4, 8'd5);
    step(1, 0, 8'h00, 1);
    check_all("clr_full", 1'b1, 1'b0, 16'h3332, 1'b0, 16'd4, 8'd5);
    step(0, 1, "1", 1);
    step(0, 1, "1", 1);
    check_all("post_clr_pair", 1'b0, 1'b1, 16'h3131, 1'b0, 16'd4, 8'd5);
    step(0, 0, 8'h00, 1);
    check_all("post_clr_hs", 1'b1, 1'b0, 16'h3131, 1'b0, 16'd5, 8'd5);

    // Reset mid-pair discards everything.
    step(0, 1, "4", 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_byte = "5";
    @(posedge clk);
    #1;
    check_all("rst_mid", 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_release", 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 8'd0);

    // Pair counter saturation.
    @(negedge clk);
    force dut.pair_count = 16'hFFFE;
    #1;
    release dut.pair_count;
    step(0, 1, "6", 1);
    step(0, 1, "7", 1);
    check_all("sat_pair0", 1'b0, 1'b1, 16'h3637, 1'b0, 16'hFFFE, 8'd0);
    step(0, 0, 8'h00, 1);
    cmp("sat_hs0", "pair_count", pair_count, 16'hFFFF);
    for (int k = 1; k < 3; k++) begin
      step(0, 1, "1", 1);
      step(0, 1, "2", 1);
      step(0, 0, 8'h00, 1);
      check_all($sformatf("sat_hs%0d", k), 1'b1, 1'b0, 16'h3132, 1'b0, 16'hFFFF, 8'd0);
    end

    // Error counter saturation.
    for (int k = 0; k < 256; k++) step(0, 1, "A", 0);
    check_all("err_sat", 1'b1, 1'b0, 16'h3132, 1'b1, 16'hFFFF, 8'hFF);
    step(0, 0, 8'h00, 0);
    check_all("err_sat_idle", 1'b1, 1'b0, 16'h3132, 1'b0, 16'hFFFF, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
